// File: rtl/arrow_count_ctrl.sv
// Up/down count controller for NES A (up) / B (down) buttons: synchronised
// inputs, one step per press, hold-to-autorepeat, wrap or saturate at range ends.
module arrow_count_ctrl #(
  parameter int WIDTH        = 4,
  parameter int MAX_VAL      = 9,
  parameter int INIT_VAL     = 0,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             a,
  input  logic             b,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             ud,
  output logic             step,
  output logic             atLimit,
  output logic [1:0]       dbg_state
);

  localparam int MAX_REP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(MAX_REP) + 1;
  localparam logic [CW-1:0]  DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0]  RATE_LAST = CW'(REPEAT_RATE - 1);
  localparam logic [WIDTH:0] MAX_E = (WIDTH+1)'(MAX_VAL);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

  // Handshake: none; a/b are level inputs, tick is a one-cycle enable, and
  // step is a one-cycle strobe valid in the cycle count has just changed.
  state_t           state_q;
  logic [CW-1:0]    tick_cnt_q;
  logic [WIDTH-1:0] count_q;
  logic             ud_q, step_q;
  logic             a_meta_q, a_s_q, b_meta_q, b_s_q;

  logic             dir_valid, dir_up;
  logic [CW-1:0]    tick_last;
  logic [WIDTH:0]   cnt_ext, up_val, dn_val, step_ext;
  logic [WIDTH-1:0] count_d;

  assign dir_valid = a_s_q ^ b_s_q;
  assign dir_up    = ~a_s_q & b_s_q;
  assign tick_last = (state_q == DELAY) ? DLY_LAST : RATE_LAST;

  always_comb begin
    cnt_ext = {1'b0, count_q};
    up_val  = (cnt_ext == MAX_E) ? ((WRAP != 0) ? '0 : cnt_ext) : cnt_ext + (WIDTH+1)'(1);
    dn_val  = (cnt_ext == '0) ? ((WRAP != 0) ? MAX_E : cnt_ext) : cnt_ext - (WIDTH+1)'(1);
    step_ext = dir_up ? up_val : dn_val;
    // Clamp keeps count inside the range even if it were ever loaded out of it.
    count_d = (step_ext > MAX_E) ? MAX_E[WIDTH-1:0] : step_ext[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      count_q    <= WIDTH'(INIT_VAL);
      ud_q       <= 1'b1;
      step_q     <= 1'b0;
      a_meta_q   <= 1'b1;
      a_s_q      <= 1'b1;
      b_meta_q   <= 1'b1;
      b_s_q      <= 1'b1;
    end else begin
      a_meta_q <= a;
      a_s_q    <= a_meta_q;
      b_meta_q <= b;
      b_s_q    <= b_meta_q;
      step_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          tick_cnt_q <= '0;
          if (dir_valid) begin
            count_q <= count_d;
            ud_q    <= dir_up;
            step_q  <= 1'b1;
            state_q <= DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (!dir_valid) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
          end else if (dir_up != ud_q) begin
            count_q    <= count_d;
            ud_q       <= dir_up;
            step_q     <= 1'b1;
            tick_cnt_q <= '0;
            state_q    <= DELAY;
          end else if (tick) begin
            if (tick_cnt_q == tick_last) begin
              count_q    <= count_d;
              step_q     <= 1'b1;
              tick_cnt_q <= '0;
              state_q    <= REPEAT;
            end else begin
              tick_cnt_q <= tick_cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          tick_cnt_q <= '0;
        end
      endcase
    end
  end

  assign count     = count_q;
  assign ud        = ud_q;
  assign step      = step_q;
  assign atLimit   = ((count_q == MAX_E[WIDTH-1:0]) && ud_q) || ((count_q == '0) && !ud_q);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_arrow_count_ctrl.sv
// Directed bench for arrow_count_ctrl: a wrapping and a saturating instance
// share the same button/tick stimulus.
module tb_arrow_count_ctrl;

  logic       clock, resetN, a, b, tick;
  logic [3:0] count_w, count_s;
  logic       ud_w, ud_s, step_w, step_s, lim_w, lim_s;
  logic [1:0] st_w, st_s;

  int n_cmp  = 0;
  int n_fail = 0;
  int nsteps = 0;

  arrow_count_ctrl #(.WRAP(1)) u_wrap (
    .clock(clock), .resetN(resetN), .a(a), .b(b), .tick(tick),
    .count(count_w), .ud(ud_w), .step(step_w), .atLimit(lim_w), .dbg_state(st_w)
  );

  arrow_count_ctrl #(.WRAP(0)) u_sat (
    .clock(clock), .resetN(resetN), .a(a), .b(b), .tick(tick),
    .count(count_s), .ud(ud_s), .step(step_s), .atLimit(lim_s), .dbg_state(st_s)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // step pulses of the wrapping instance, sampled after each rising edge
  always begin
    @(posedge clock);
    #2;
    if (step_w) nsteps++;
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clock);
    a = 1'b1; b = 1'b1; tick = 1'b0; resetN = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    a = 1'b0; b = 1'b0; tick = 1'b0; resetN = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (count_w !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_w); end
    n_cmp++; if (ud_w !== 1'b1) begin n_fail++; $display("FAIL reset_ud got %b want 1", ud_w); end
    n_cmp++; if (step_w !== 1'b0) begin n_fail++; $display("FAIL reset_step got %b want 0", step_w); end
    n_cmp++; if (st_w !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", st_w); end
    n_cmp++; if (count_s !== 4'd0) begin n_fail++; $display("FAIL reset_count_sat got %0d want 0", count_s); end
    @(negedge clock);
    resetN = 1'b1;
    begin
      int base;
      base = nsteps;
      repeat (6) @(negedge clock);
      n_cmp++; if (nsteps - base !== 0) begin n_fail++; $display("FAIL both_held_steps got %0d want 0", nsteps - base); end
      n_cmp++; if (count_w !== 4'd0) begin n_fail++; $display("FAIL both_held_count got %0d want 0", count_w); end
    end
    a = 1'b1; b = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_single_press();
    int base;
    base = nsteps;
    a = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (step_w !== 1'b0) begin n_fail++; $display("FAIL press_edge_k step got %b want 0", step_w); end
    @(posedge clock); #1;
    n_cmp++; if (step_w !== 1'b0) begin n_fail++; $display("FAIL press_edge_k1 step got %b want 0", step_w); end
    @(posedge clock); #1;
    n_cmp++; if (step_w !== 1'b1) begin n_fail++; $display("FAIL press_edge_k2 step got %b want 1", step_w); end
    n_cmp++; if (count_w !== 4'd1) begin n_fail++; $display("FAIL press_count got %0d want 1", count_w); end
    n_cmp++; if (ud_w !== 1'b1) begin n_fail++; $display("FAIL press_ud got %b want 1", ud_w); end
    repeat (3) @(negedge clock);
    a = 1'b1;
    repeat (4) @(negedge clock);
    n_cmp++; if (nsteps - base !== 1) begin n_fail++; $display("FAIL press_total_steps got %0d want 1", nsteps - base); end
    n_cmp++; if (st_w !== 2'd0) begin n_fail++; $display("FAIL press_release_state got %0d want 0", st_w); end
    n_cmp++; if (count_w !== 4'd1) begin n_fail++; $display("FAIL press_release_count got %0d want 1", count_w); end
  endtask

  task automatic test_autorepeat();
    int base;
    int exp_steps [20];
    exp_steps = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 8};
    do_reset();
    base = nsteps;
    a = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (nsteps - base !== 1) begin n_fail++; $display("FAIL rep_first_step got %0d want 1", nsteps - base); end
    n_cmp++; if (st_w !== 2'd1) begin n_fail++; $display("FAIL rep_delay_state got %0d want 1", st_w); end
    for (int i = 0; i < 20; i++) begin
      pulse_tick();
      n_cmp++;
      if (nsteps - base !== exp_steps[i]) begin
        n_fail++; $display("FAIL rep_steps_after_tick%0d got %0d want %0d", i + 1, nsteps - base, exp_steps[i]);
      end
    end
    n_cmp++; if (count_w !== 4'd8) begin n_fail++; $display("FAIL rep_count got %0d want 8", count_w); end
    n_cmp++; if (count_s !== 4'd8) begin n_fail++; $display("FAIL rep_count_sat got %0d want 8", count_s); end
    n_cmp++; if (st_w !== 2'd2) begin n_fail++; $display("FAIL rep_state got %0d want 2", st_w); end
  endtask

  task automatic test_back_to_back();
    int base;
    b = 1'b0;
    repeat (4) @(negedge clock);
    n_cmp++; if (st_w !== 2'd0) begin n_fail++; $display("FAIL both_state got %0d want 0", st_w); end
    base = nsteps;
    repeat (4) pulse_tick();
    n_cmp++; if (nsteps - base !== 0) begin n_fail++; $display("FAIL both_steps got %0d want 0", nsteps - base); end
    n_cmp++; if (count_w !== 4'd8) begin n_fail++; $display("FAIL both_count got %0d want 8", count_w); end
    a = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (step_w !== 1'b1) begin n_fail++; $display("FAIL down_step got %b want 1", step_w); end
    n_cmp++; if (count_w !== 4'd7) begin n_fail++; $display("FAIL down_count got %0d want 7", count_w); end
    n_cmp++; if (ud_w !== 1'b0) begin n_fail++; $display("FAIL down_ud got %b want 0", ud_w); end
    n_cmp++; if (st_w !== 2'd1) begin n_fail++; $display("FAIL down_state got %0d want 1", st_w); end
    @(negedge clock);
    base = nsteps;
    repeat (7) pulse_tick();
    n_cmp++; if (nsteps - base !== 0) begin n_fail++; $display("FAIL down_delay7 got %0d want 0", nsteps - base); end
    pulse_tick();
    n_cmp++; if (nsteps - base !== 1) begin n_fail++; $display("FAIL down_delay8 got %0d want 1", nsteps - base); end
    n_cmp++; if (count_w !== 4'd6) begin n_fail++; $display("FAIL down_repeat_count got %0d want 6", count_w); end
    // swap direction in one cycle: no idle gap, immediate up step
    a = 1'b0; b = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (step_w !== 1'b1) begin n_fail++; $display("FAIL swap_step got %b want 1", step_w); end
    n_cmp++; if (count_w !== 4'd7) begin n_fail++; $display("FAIL swap_count got %0d want 7", count_w); end
    n_cmp++; if (ud_w !== 1'b1) begin n_fail++; $display("FAIL swap_ud got %b want 1", ud_w); end
    n_cmp++; if (st_w !== 2'd1) begin n_fail++; $display("FAIL swap_state got %0d want 1", st_w); end
    @(negedge clock);
    a = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_wrap_sat();
    do_reset();
    b = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (count_w !== 4'd9) begin n_fail++; $display("FAIL wrap_down_count got %0d want 9", count_w); end
    n_cmp++; if (ud_w !== 1'b0) begin n_fail++; $display("FAIL wrap_down_ud got %b want 0", ud_w); end
    n_cmp++; if (lim_w !== 1'b0) begin n_fail++; $display("FAIL wrap_down_limit got %b want 0", lim_w); end
    n_cmp++; if (count_s !== 4'd0) begin n_fail++; $display("FAIL sat_down_count got %0d want 0", count_s); end
    n_cmp++; if (step_s !== 1'b1) begin n_fail++; $display("FAIL sat_down_step got %b want 1", step_s); end
    n_cmp++; if (lim_s !== 1'b1) begin n_fail++; $display("FAIL sat_down_limit got %b want 1", lim_s); end
    @(negedge clock);
    b = 1'b1;
    repeat (4) @(negedge clock);
    do_reset();
    repeat (9) begin
      a = 1'b0;
      repeat (3) @(negedge clock);
      a = 1'b1;
      repeat (3) @(negedge clock);
    end
    n_cmp++; if (count_w !== 4'd9) begin n_fail++; $display("FAIL up9_count got %0d want 9", count_w); end
    n_cmp++; if (count_s !== 4'd9) begin n_fail++; $display("FAIL up9_count_sat got %0d want 9", count_s); end
    n_cmp++; if (lim_w !== 1'b1) begin n_fail++; $display("FAIL up9_limit got %b want 1", lim_w); end
    a = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (count_w !== 4'd0) begin n_fail++; $display("FAIL wrap_up_count got %0d want 0", count_w); end
    n_cmp++; if (step_w !== 1'b1) begin n_fail++; $display("FAIL wrap_up_step got %b want 1", step_w); end
    n_cmp++; if (lim_w !== 1'b0) begin n_fail++; $display("FAIL wrap_up_limit got %b want 0", lim_w); end
    n_cmp++; if (count_s !== 4'd9) begin n_fail++; $display("FAIL sat_up_count got %0d want 9", count_s); end
    n_cmp++; if (step_s !== 1'b1) begin n_fail++; $display("FAIL sat_up_step got %b want 1", step_s); end
    n_cmp++; if (lim_s !== 1'b1) begin n_fail++; $display("FAIL sat_up_limit got %b want 1", lim_s); end
    @(negedge clock);
    a = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    resetN = 1'b1; a = 1'b1; b = 1'b1; tick = 1'b0;
    test_reset();
    test_single_press();
    test_autorepeat();
    test_back_to_back();
    test_wrap_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/arrow_count_ctrl.md
Name: arrow_count_ctrl

Overview:
- Parametrised successor of the NES A/B count-direction logic.
- Replaces clock gating with a synchronous, single-clock up/down counter controller. A = up, B = down; NES buttons are active low.
- Adds input synchronisation, one step per press, hold-to-autorepeat, a configurable range, and wrap or saturate mode.
- Sits between the NES controller receiver (button bits) and the digit display logic.

Parameters:
- WIDTH, 4, count width in bits.
- MAX_VAL, 9, upper count limit. Legal range: 1 <= MAX_VAL <= 2**WIDTH-1.
- INIT_VAL, 0, count value after reset. Must be <= MAX_VAL.
- WRAP, 1, overflow mode. 1 = wrap (MAX_VAL->0 up, 0->MAX_VAL down); 0 = saturate at 0 / MAX_VAL.
- REPEAT_DELAY, 8, number of tick pulses a button must be held after the first step before autorepeat starts. Must be >= 1.
- REPEAT_RATE, 2, number of tick pulses between autorepeat steps. Must be >= 1.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetN  in  1  synchronous, active-low reset.
- a  in  1  NES A button, active low, asynchronous to clock.
- b  in  1  NES B button, active low, asynchronous to clock.
- tick  in  1  single-cycle timebase enable pulse for delay/repeat timing.
- count  out  WIDTH  current count value.
- ud  out  1  direction of the most recent step; 1 = up, 0 = down.
- step  out  1  one-cycle pulse, high in the cycle count has just changed.
- atLimit  out  1  combinational; high when count==MAX_VAL and ud=1, or count==0 and ud=0.

Behaviour:
- Reset: resetN sampled low at a rising edge sets:
  - count=INIT_VAL, ud=1, step=0, state=IDLE, tick counter=0;
  - both synchroniser stages to 1 (released).
- Reset mid-hold takes effect on that edge and discards all timing state.
- Synchroniser: a and b each pass through a 2-flop synchroniser (aS, bS). All decoding uses aS/bS only.
- Decode:
  - dirValid = aS ^ bS;
  - dirUp = ~aS & bS.
  - Both pressed or neither pressed gives dirValid=0, i.e. hold.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE:
    - dirValid=1 -> perform step, tick counter=0, go DELAY.
    - Otherwise stay; step=0.
  - DELAY:
    - On tick, tick counter increments.
    - On a tick with counter==REPEAT_DELAY-1 -> perform step, counter=0, go REPEAT.
  - REPEAT: on a tick with counter==REPEAT_RATE-1 -> perform step, counter=0; otherwise counter increments on tick.
  - DELAY or REPEAT with dirValid=0 -> IDLE next edge, no step.
  - DELAY or REPEAT with a direction change (dirUp differs from latched direction) -> treated as a new press: perform step in the new direction, counter=0, go DELAY.
- Perform step: all of the following register on the same edge.
  - ud = dirUp; step=1.
  - Up: count+1, or 0 if count==MAX_VAL and WRAP=1; count unchanged if count==MAX_VAL and WRAP=0.
  - Down: count-1, or MAX_VAL if count==0 and WRAP=1; unchanged if count==0 and WRAP=0.
  - A saturated step still pulses step=1 with count unchanged.
- Latency: input a falls before edge k -> aS low after edge k+1 -> count/step update at edge k+2.
- tick coinciding with a state transition: the tick is consumed by the transition, not double counted.
- Arithmetic uses WIDTH+1 bits internally. count never exceeds MAX_VAL.
- Tick counter width: clog2 of max(REPEAT_DELAY, REPEAT_RATE), plus 1.

Test Plan:
- Reset: hold resetN=0 for 2 clocks with a=b=0 -> count=0, ud=1, step=0. Release with buttons still pressed (both) -> count stays 0.
- Single press: a=0 for 5 clocks, tick=0 -> exactly one step pulse at edge k+2, count 0->1, ud=1. Release -> IDLE, no further steps.
- Autorepeat: a held, tick every 4 clocks for 20 ticks, defaults -> steps after 0, 8, 10, 12, 14, 16, 18, 20 ticks. count=8 at end.
- Wrap/saturate, down direction: from count=0, b=0 pulse -> WRAP=1 gives count=9; WRAP=0 gives count stays 0, step=1, atLimit=1.
- Up direction at limit: from count=9, a=0 pulse -> WRAP=1 gives count=0; WRAP=0 gives count stays 9, atLimit=1.
- Both pressed / direction change: a held into REPEAT, then b also pressed -> IDLE, count frozen. Then a released, b held -> immediate down step, DELAY restarts (next step after 8 ticks).
